// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-word field positions and payload types for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 11;
    localparam int unsigned CNT_W  = 16;

    // Bit positions within the packed decode control word (MSB first)
    localparam int unsigned CTRL_REGDST    = 10;
    localparam int unsigned CTRL_ALUSRC    = 9;
    localparam int unsigned CTRL_MEMTOREG  = 8;
    localparam int unsigned CTRL_REGWRITE  = 7;
    localparam int unsigned CTRL_MEMREAD   = 6;
    localparam int unsigned CTRL_MEMWRITE  = 5;
    localparam int unsigned CTRL_BRANCH    = 4;
    localparam int unsigned CTRL_ALUOP_HI  = 3;
    localparam int unsigned CTRL_ALUOP_LO  = 2;
    localparam int unsigned CTRL_JUMP      = 1;
    localparam int unsigned CTRL_SIGNZERO  = 0;

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } idex_data_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-side inputs, execute-side registered copies, hazard status.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              id_valid_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic [DATA_W-1:0] id_pc4_i;
    logic [DATA_W-1:0] id_rdata1_i;
    logic [DATA_W-1:0] id_rdata2_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_W-1:0]  id_rs_i;
    logic [REG_W-1:0]  id_rt_i;
    logic [REG_W-1:0]  id_rd_i;
    logic              flush_i;

    logic              ex_valid_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [DATA_W-1:0] ex_pc4_o;
    logic [DATA_W-1:0] ex_rdata1_o;
    logic [DATA_W-1:0] ex_rdata2_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_W-1:0]  ex_rs_o;
    logic [REG_W-1:0]  ex_rt_o;
    logic [REG_W-1:0]  ex_rd_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output id_valid_i, id_ctrl_i, id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, flush_i,
        input  ex_valid_o, ex_ctrl_o, ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  id_valid_i, id_ctrl_i, id_pc4_i, id_rdata1_i, id_rdata2_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, flush_i,
        output ex_valid_o, ex_ctrl_o, ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o,
               ex_rs_o, ex_rt_o, ex_rd_o, stall_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             i_flush,
    input  logic             i_id_valid,
    input  logic             i_id_reg_dst,
    input  logic             i_id_mem_write,
    input  logic             i_id_branch,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    output logic             o_stall_c
);

    logic w_uses_rt;
    logic w_rs_hit;
    logic w_rt_hit;

    // rt is a source for R-type, stores and branches; otherwise it is a destination
    assign w_uses_rt = i_id_reg_dst | i_id_mem_write | i_id_branch;
    assign w_rs_hit  = (i_ex_rt == i_id_rs);
    assign w_rt_hit  = w_uses_rt & (i_ex_rt == i_id_rt);

    assign o_stall_c = !i_flush & i_id_valid & i_ex_valid & i_ex_mem_read
                     & (i_ex_rt != '0) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_ex_valid;
    logic [CTRL_W-1:0] r_ex_ctrl;
    idex_data_t        r_ex_data;
    logic [CNT_W-1:0]  r_bubble_cnt;
    idex_data_t        w_id_data;
    logic              w_stall;
    logic              w_kill;

    hazard_detect u_hazard_detect (
        .i_flush        (bus.flush_i),
        .i_id_valid     (bus.id_valid_i),
        .i_id_reg_dst   (bus.id_ctrl_i[CTRL_REGDST]),
        .i_id_mem_write (bus.id_ctrl_i[CTRL_MEMWRITE]),
        .i_id_branch    (bus.id_ctrl_i[CTRL_BRANCH]),
        .i_id_rs        (bus.id_rs_i),
        .i_id_rt        (bus.id_rt_i),
        .i_ex_valid     (r_ex_valid),
        .i_ex_mem_read  (r_ex_ctrl[CTRL_MEMREAD]),
        .i_ex_rt        (r_ex_data.rt),
        .o_stall_c      (w_stall)
    );

    assign w_id_data = '{
        pc4:    bus.id_pc4_i,
        rdata1: bus.id_rdata1_i,
        rdata2: bus.id_rdata2_i,
        imm:    bus.id_imm_i,
        rs:     bus.id_rs_i,
        rt:     bus.id_rt_i,
        rd:     bus.id_rd_i
    };

    // Flush, load-use stall or an empty decode slot all turn into a bubble in EX
    assign w_kill = bus.flush_i | w_stall | !bus.id_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_data  <= '0;
        end else begin
            r_ex_data <= w_id_data;
            if (w_kill) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= bus.id_ctrl_i;
            end
        end
    end

    // Counts stall cycles only; flushes are not bubbles from this stage's point of view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_stall && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_valid_o   = r_ex_valid;
    assign bus.ex_ctrl_o    = r_ex_ctrl;
    assign bus.ex_pc4_o     = r_ex_data.pc4;
    assign bus.ex_rdata1_o  = r_ex_data.rdata1;
    assign bus.ex_rdata2_o  = r_ex_data.rdata2;
    assign bus.ex_imm_o     = r_ex_data.imm;
    assign bus.ex_rs_o      = r_ex_data.rs;
    assign bus.ex_rt_o      = r_ex_data.rt;
    assign bus.ex_rd_o      = r_ex_data.rd;
    assign bus.stall_o      = w_stall;
    assign bus.bubble_cnt_o = r_bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width; REG_W, 5, register-index width; CTRL_W, 11, packed control-word width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 id_valid_i  input  1  decode stage holds a real instruction.
REQ-005 id_ctrl_i  input  CTRL_W  packed decode controls, MSB..LSB: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], Jump, SignZero.
REQ-006 id_pc4_i  input  DATA_W  PC+4 of decode instruction.
REQ-007 id_rdata1_i  input  DATA_W  register-file read port 1 (rs).
REQ-008 id_rdata2_i  input  DATA_W  register-file read port 2 (rt).
REQ-009 id_imm_i  input  DATA_W  extended immediate.
REQ-010 id_rs_i  input  REG_W  rs field.
REQ-011 id_rt_i  input  REG_W  rt field.
REQ-012 id_rd_i  input  REG_W  rd field.
REQ-013 flush_i  input  1  taken branch/jump resolved downstream; kill decode instruction.
REQ-014 ex_valid_o  output  1  execute-stage instruction valid.
REQ-015 ex_ctrl_o, ex_pc4_o, ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o  output  widths as matching inputs  registered copies for execute stage.
REQ-016 stall_o  output  1  hold PC and IF/ID register this cycle.
REQ-017 bubble_cnt_o  output  16  count of inserted bubbles, saturating.

Function
REQ-018 Normal advance (id_valid_i=1, no stall, no flush): every ex_* register SHALL load its id_* input on the edge; ex_valid_o<=1; latency exactly 1 cycle.
REQ-019 stall_o SHALL be combinational: !flush_i & id_valid_i & ex_valid_o & ex_ctrl_o.MemRead & (ex_rt_o!=0) & ((ex_rt_o==id_rs_i) | (uses_rt & ex_rt_o==id_rt_i)).
REQ-020 uses_rt SHALL equal id_ctrl_i.RegDst | id_ctrl_i.MemWrite | id_ctrl_i.Branch.
REQ-021 While stall_o=1 the stage SHALL insert a bubble: ex_valid_o<=0, ex_ctrl_o<=0; data/index registers load inputs (don't-care).
REQ-022 flush_i=1 SHALL take priority over stall: ex_valid_o<=0, ex_ctrl_o<=0, stall_o=0.
REQ-023 id_valid_i=0 SHALL load ex_valid_o<=0 and ex_ctrl_o<=0.
REQ-024 Load-use stall SHALL last exactly one cycle per hazard (next cycle ex holds the bubble, MemRead=0).
REQ-025 bubble_cnt_o SHALL increment by 1 on each edge where stall_o=1, saturating at 0xFFFF; flush does not count.
REQ-026 Register $0 (index 0) SHALL never cause a stall.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all outputs/registers to 0 (ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=0); stall_o=0 follows.
REQ-028 Reset mid-stall SHALL drop stall_o immediately; first post-reset edge with valid input advances normally.

Structure
REQ-029 Shared package SHALL hold CTRL_W, DATA_W, REG_W and bit-index constants for each control field.
REQ-030 One sub-module hazard_detect SHALL implement REQ-019/020 combinationally; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-031 lw $8 in EX, add using rs=8 in ID -> stall_o=1 one cycle, ex_ctrl_o=0 next edge, bubble_cnt_o 0->1, add enters EX the following edge.
REQ-032 lw $8 in EX, addi with rt=8 (RegDst=0, MemWrite=0, Branch=0) -> stall_o=0, no bubble.
REQ-033 lw $0 in EX, add rs=0 -> stall_o=0.
REQ-034 load-use hazard coincident with flush_i=1 -> stall_o=0, ex_valid_o=0, bubble_cnt_o unchanged.
REQ-035 preload bubble_cnt_o=0xFFFF via 65535 hazards, one more hazard -> stays 0xFFFF.
REQ-036 rst_n low between edges while stall_o=1 -> outputs 0 immediately, no edge required.
